// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte sources:
//   requester 0 : CPU store path
//   requester 1 : debug / trace source
// Arbitration is round-robin with a per-packet lock: once a requester has a
// byte accepted with last=0 it keeps the transmitter until it sends a byte
// with last=1 or leaves valid low for LOCK_TIMEOUT idle cycles. Each byte is
// serialised against the UART tx_busy handshake.
//
// Optional feature: define ARB_STATS_EN to add saturating statistics
// outputs (stat_bytes0, stat_bytes1, stat_timeouts).
//
// Parameters
//   LOCK_TIMEOUT  idle cycles a locked requester may keep valid low (>=2)
//   START_GUARD   cycles to wait for tx_busy to rise after tx_we (>=1)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req0_data/valid/last      requester 0 byte stream (valid held until ready)
//   req0_ready                requester 0 byte accepted this cycle
//   req1_data/valid/last      requester 1 byte stream
//   req1_ready                requester 1 byte accepted this cycle
//   tx_data                   byte to UART, stable from tx_we until IDLE
//   tx_we                     one-cycle write pulse per byte
//   tx_busy                   UART busy input
//   grant_id                  owner of the packet lock (valid with lock_active)
//   lock_active               a requester holds the packet lock
//   stat_bytes0/1             accepted bytes per requester   (ARB_STATS_EN)
//   stat_timeouts             lock timeouts                  (ARB_STATS_EN)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int LOCK_TIMEOUT = 256,
    parameter int START_GUARD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_we,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       lock_active
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_bytes0,
    output logic [15:0] stat_bytes1,
    output logic [7:0]  stat_timeouts
`endif
);

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int GW = $clog2(START_GUARD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PULSE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t        state;
    logic          rr;
    logic [TW-1:0] lock_cnt;
    logic [GW-1:0] guard_cnt;

    logic          sel;
    logic          sel_valid;
    logic          sel_last;
    logic [7:0]    sel_data;
    logic          owner_valid;
    logic          accept;
    logic          timeout_hit;

    // While locked only the owner is considered; otherwise a lone valid
    // requester wins, and contention is resolved by the round-robin pointer.
    always_comb begin
        sel       = 1'b0;
        sel_valid = 1'b0;
        if (lock_active) begin
            sel       = grant_id;
            sel_valid = grant_id ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            sel       = rr;
            sel_valid = 1'b1;
        end else if (req0_valid) begin
            sel       = 1'b0;
            sel_valid = 1'b1;
        end else if (req1_valid) begin
            sel       = 1'b1;
            sel_valid = 1'b1;
        end
    end

    assign sel_last    = sel ? req1_last : req0_last;
    assign sel_data    = sel ? req1_data : req0_data;
    assign owner_valid = grant_id ? req1_valid : req0_valid;

    // ready is combinational so that valid&&ready marks the transfer in the
    // same cycle; it is gated by rst so nothing is accepted during reset.
    assign accept     = (state == S_IDLE) && !tx_busy && !rst && sel_valid;
    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;

    assign timeout_hit = (state == S_IDLE) && lock_active && !owner_valid &&
                         (lock_cnt == TW'(LOCK_TIMEOUT - 1));

    // Byte sequencing FSM plus lock / round-robin bookkeeping. A timed-out
    // lock hands priority to the other requester, same as a finished packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr          <= 1'b0;
            lock_cnt    <= '0;
            guard_cnt   <= '0;
            tx_data     <= 8'h00;
            tx_we       <= 1'b0;
            grant_id    <= 1'b0;
            lock_active <= 1'b0;
        end else begin
            tx_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tx_data     <= sel_data;
                        grant_id    <= sel;
                        lock_active <= !sel_last;
                        if (sel_last) begin
                            rr <= ~sel;
                        end
                        lock_cnt <= '0;
                        state    <= S_LOAD;
                    end else if (timeout_hit) begin
                        lock_active <= 1'b0;
                        rr          <= ~grant_id;
                        lock_cnt    <= '0;
                    end else if (lock_active && !owner_valid) begin
                        lock_cnt <= lock_cnt + TW'(1);
                    end
                end
                S_LOAD: begin
                    tx_we <= 1'b1;
                    state <= S_PULSE;
                end
                S_PULSE: begin
                    guard_cnt <= '0;
                    state     <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (guard_cnt == GW'(START_GUARD - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating per-requester byte counters and lock-timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bytes0   <= 16'h0000;
            stat_bytes1   <= 16'h0000;
            stat_timeouts <= 8'h00;
        end else begin
            if (req0_ready && stat_bytes0 != 16'hFFFF) begin
                stat_bytes0 <= stat_bytes0 + 16'h0001;
            end
            if (req1_ready && stat_bytes1 != 16'hFFFF) begin
                stat_bytes1 <= stat_bytes1 + 16'h0001;
            end
            if (timeout_hit && stat_timeouts != 8'hFF) begin
                stat_timeouts <= stat_timeouts + 8'h01;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (LOCK_TIMEOUT=16, START_GUARD=4).
// Two queue-backed byte sources and a simple UART busy model drive the DUT.
// A timeline model of the arbitration rules predicts ready, tx_we, tx_data
// and lock state every cycle; directed scenarios add literal expectations
// on accepted byte order and byte-to-byte spacing.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int LT = 16;
    localparam int SG = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] tx_data;
    logic       tx_we, tx_busy, grant_id, lock_active;
`ifdef ARB_STATS_EN
    logic [15:0] stat_bytes0, stat_bytes1;
    logic [7:0]  stat_timeouts;
`endif

    uart_tx_arbiter #(.LOCK_TIMEOUT(LT), .START_GUARD(SG)) dut (
        .clk(clk), .rst(rst),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
        .grant_id(grant_id), .lock_active(lock_active)
`ifdef ARB_STATS_EN
        , .stat_bytes0(stat_bytes0), .stat_bytes1(stat_bytes1), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Sources: entry = {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    bit en0 = 1'b1, en1 = 1'b1;

    // UART model
    int frame_len = 10;
    bit silent = 1'b0;
    bit ext_busy = 1'b0;
    int busy_cnt = 0;

    bit hs0, hs1, we_seen;

    // Timeline model of the arbiter
    int         cyc = 0;
    bit         m_idle = 1'b1, m_lock = 1'b0, m_owner = 1'b0, m_rr = 1'b0;
    int         m_to = 0;
    logic [7:0] m_data = 8'h00;
    int         we_due = -1;
    bit         m_seen_busy = 1'b0;
    int         m_touts = 0;
    int         we_total = 0;
    logic [8:0] acc_log[$];
    int         acc_cyc[$];
    bit         e_sel, e_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [8:0] get_acc(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 9'h1FF;
    endfunction

    function automatic int get_cyc(input int i);
        if (i < acc_cyc.size()) return acc_cyc[i];
        return -1000;
    endfunction

    task automatic drive_inputs();
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = req0_valid ? q0[0][7:0] : 8'h00;
        req0_last  = req0_valid ? q0[0][8] : 1'b0;
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = req1_valid ? q1[0][7:0] : 8'h00;
        req1_last  = req1_valid ? q1[0][8] : 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        if (we_seen && !silent) busy_cnt = frame_len;
        tx_busy = ext_busy || (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        drive_inputs();
    endtask

    task automatic wait_drain(input int maxc);
        bit done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && m_idle && busy_cnt == 0 && !tx_busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout cyc=%0d actual=busy required=idle", cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        cyc++;
        e_sel = 1'b0;
        e_acc = 1'b0;
        if (m_idle && !tx_busy && !rst) begin
            if (m_lock) begin
                e_sel = m_owner;
                e_acc = m_owner ? req1_valid : req0_valid;
            end else if (req0_valid && req1_valid) begin
                e_sel = m_rr;
                e_acc = 1'b1;
            end else if (req0_valid || req1_valid) begin
                e_sel = req1_valid;
                e_acc = 1'b1;
            end
        end
        check("req0_ready", 32'(req0_ready), 32'(e_acc && !e_sel));
        check("req1_ready", 32'(req1_ready), 32'(e_acc && e_sel));
        check("tx_we", 32'(tx_we), 32'(cyc == we_due));
        check("lock_active", 32'(lock_active), 32'(m_lock));
        if (m_lock) check("grant_id", 32'(grant_id), 32'(m_owner));
        check("tx_data", 32'(tx_data), 32'(m_data));

        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        we_seen = tx_we;
        if (tx_we) we_total++;

        if (rst) begin
            m_idle = 1'b1; m_lock = 1'b0; m_owner = 1'b0; m_rr = 1'b0;
            m_to = 0; m_data = 8'h00; we_due = -1; m_seen_busy = 1'b0; m_touts = 0;
        end else if (e_acc) begin
            m_data = e_sel ? req1_data : req0_data;
            acc_log.push_back({e_sel, m_data});
            acc_cyc.push_back(cyc);
            m_owner = e_sel;
            m_lock = !(e_sel ? req1_last : req0_last);
            if (!m_lock) m_rr = !e_sel;
            m_to = 0;
            m_idle = 1'b0;
            m_seen_busy = 1'b0;
            we_due = cyc + 2;
        end else if (m_idle && m_lock && !(m_owner ? req1_valid : req0_valid)) begin
            m_to++;
            if (m_to == LT) begin
                m_lock = 1'b0;
                m_rr = !m_owner;
                m_to = 0;
                m_touts++;
            end
        end else if (!m_idle && cyc > we_due) begin
            if (!m_seen_busy) begin
                if (tx_busy) m_seen_busy = 1'b1;
                else if (cyc == we_due + SG) m_idle = 1'b1;
            end else if (!tx_busy) begin
                m_idle = 1'b1;
            end
        end
    end

    initial begin
        int base;
        int wbase;
        rst = 1'b1;
        tx_busy = 1'b0;
        hs0 = 1'b0; hs1 = 1'b0; we_seen = 1'b0;
        drive_inputs();
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_lock", 32'(lock_active), 32'h0);
        check("reset_txdata", 32'(tx_data), 32'h0);

        // 1: single byte from req0
        base = acc_log.size();
        wbase = we_total;
        q0.push_back({1'b1, 8'h41});
        drive_inputs();
        wait_drain(60);
        check("t1_count", 32'(acc_log.size() - base), 32'd1);
        check("t1_byte", 32'(get_acc(base)), 32'h041);
        check("t1_we_pulses", 32'(we_total - wbase), 32'd1);
        check("t1_txdata_held", 32'(tx_data), 32'h41);

        // 2: contention from reset, then contention again
        rst = 1'b1;
        step();
        rst = 1'b0;
        base = acc_log.size();
        q0.push_back({1'b1, 8'h30});
        q1.push_back({1'b1, 8'h31});
        drive_inputs();
        wait_drain(100);
        q0.push_back({1'b1, 8'h32});
        q1.push_back({1'b1, 8'h33});
        drive_inputs();
        wait_drain(100);
        check("t2_first", 32'(get_acc(base)), 32'h030);
        check("t2_second", 32'(get_acc(base + 1)), 32'h131);
        check("t2_third", 32'(get_acc(base + 2)), 32'h032);
        check("t2_fourth", 32'(get_acc(base + 3)), 32'h133);

        // 3: req1 packet locked against a waiting req0
        base = acc_log.size();
        q1.push_back({1'b0, 8'hAA});
        q1.push_back({1'b0, 8'hBB});
        q1.push_back({1'b1, 8'hCC});
        drive_inputs();
        step();
        step();
        q0.push_back({1'b1, 8'h10});
        drive_inputs();
        wait_drain(150);
        check("t3_b0", 32'(get_acc(base)), 32'h1AA);
        check("t3_b1", 32'(get_acc(base + 1)), 32'h1BB);
        check("t3_b2", 32'(get_acc(base + 2)), 32'h1CC);
        check("t3_b3", 32'(get_acc(base + 3)), 32'h010);

        // 4: req0 locks then goes silent; lock times out after 16 idle cycles
        base = acc_log.size();
        q0.push_back({1'b0, 8'h50});
        drive_inputs();
        step();
        step();
        q1.push_back({1'b1, 8'h60});
        drive_inputs();
        wait_drain(150);
        check("t4_b0", 32'(get_acc(base)), 32'h050);
        check("t4_b1", 32'(get_acc(base + 1)), 32'h160);
        check("t4_gap", 32'(get_cyc(base + 1) - get_cyc(base)), 32'd30);
        check("t4_timeouts", 32'(m_touts), 32'd1);

        // 5: UART never reports busy; start guard releases the FSM
        silent = 1'b1;
        base = acc_log.size();
        q0.push_back({1'b1, 8'h77});
        q0.push_back({1'b1, 8'h78});
        drive_inputs();
        wait_drain(60);
        check("t5_b1", 32'(get_acc(base + 1)), 32'h078);
        check("t5_gap", 32'(get_cyc(base + 1) - get_cyc(base)), 32'd7);
        silent = 1'b0;

        // External busy blocks grants; a valid dropped before ready is not taken
        base = acc_log.size();
        ext_busy = 1'b1;
        step();
        q0.push_back({1'b1, 8'h11});
        drive_inputs();
        repeat (4) step();
        en0 = 1'b0;
        drive_inputs();
        ext_busy = 1'b0;
        repeat (5) step();
        check("busy_block", 32'(acc_log.size() - base), 32'd0);
        q0.delete();
        en0 = 1'b1;
        q1.push_back({1'b1, 8'h99});
        drive_inputs();
        wait_drain(60);
        check("after_busy", 32'(get_acc(base)), 32'h199);

        // 6: reset while waiting for the UART to finish
        q0.push_back({1'b0, 8'h5A});
        drive_inputs();
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_lock", 32'(lock_active), 32'h0);
        check("t6_we", 32'(tx_we), 32'h0);
        check("t6_txdata", 32'(tx_data), 32'h0);
        check("t6_grant", 32'(grant_id), 32'h0);
        check("t6_ready0", 32'(req0_ready), 32'h0);
        wait_drain(60);

`ifdef ARB_STATS_EN
        check("stat0_reset", 32'(stat_bytes0), 32'd0);
        q0.push_back({1'b1, 8'h01});
        q1.push_back({1'b1, 8'h02});
        drive_inputs();
        wait_drain(100);
        check("stat_bytes0", 32'(stat_bytes0), 32'd1);
        check("stat_bytes1", 32'(stat_bytes1), 32'd1);
        check("stat_timeouts", 32'(stat_timeouts), 32'd0);
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
